udp_frame_gen: RTL and testbench

UDP_FRAME_GEN -- requirements
Module: udp_frame_gen

---
 rtl/udp_frame_gen.sv | 203 ++++++++++++++++++++
 tb/tb_udp_frame_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_frame_gen.sv
// udp_frame_gen: emits one Ethernet II / IPv4 / UDP frame on a GMII byte
// interface per accepted start: preamble+SFD, a 42-byte header built from the
// parameters and the latched length, the payload streamed from a FWFT source,
// zero padding up to the 46-byte Ethernet minimum, the CRC-32 FCS, and then a
// fixed inter-frame gap.
module udp_frame_gen #(
  parameter logic [47:0] LOCAL_MAC = 48'ha0_b1_c2_d3_e1_e1,
  parameter logic [47:0] DEST_MAC  = 48'hff_ff_ff_ff_ff_ff,
  parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_01_0B,
  parameter logic [31:0] DEST_IP   = 32'hC0_A8_01_69,
  parameter logic [15:0] LOCL_PORT = 16'h1F90,
  parameter logic [15:0] DEST_PORT = 16'h1F90,
  parameter int          MAX_LEN   = 1472,
  parameter int          IFG_CYC   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pay_len,
  output logic        pay_rd,
  input  logic [7:0]  pay_data,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        busy,
  output logic        done,
  output logic        len_err
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    PAD,
    FCS,
    IFG
  } state_t;

  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);
  localparam logic [15:0] IFG_LAST  = 16'(IFG_CYC - 1);
  localparam logic [15:0] MIN_PAY   = 16'd18;

  state_t       state, next_state;
  logic [15:0]  cnt, next_cnt;
  logic [15:0]  len, next_len;
  logic [15:0]  ident, next_ident;
  logic [31:0]  crc, next_crc;
  logic         next_len_err;

  logic [15:0]  total_len;
  logic [15:0]  udp_len;
  logic [19:0]  csum_acc;
  logic [16:0]  csum_f1;
  logic [15:0]  csum_f2;
  logic [15:0]  ip_csum;
  logic [335:0] hdr;
  logic [5:0]   hdr_idx;
  logic [8:0]   hdr_pos;
  logic [7:0]   hdr_byte;
  logic [31:0]  crc_inv;
  logic [7:0]   fcs_byte;

  // One byte of the reflected IEEE 802.3 CRC-32, data taken LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Header fields, IPv4 checksum and the byte selected by the header/FCS index.
  always_comb begin
    total_len = len + 16'd28;
    udp_len   = len + 16'd8;
    csum_acc  = 20'h04500 + {4'd0, total_len} + {4'd0, ident} + 20'h04000 +
                20'h04011 + {4'd0, LOCAL_IP[31:16]} + {4'd0, LOCAL_IP[15:0]} +
                {4'd0, DEST_IP[31:16]} + {4'd0, DEST_IP[15:0]};
    csum_f1   = {1'b0, csum_acc[15:0]} + {13'd0, csum_acc[19:16]};
    csum_f2   = csum_f1[15:0] + {15'd0, csum_f1[16]};
    ip_csum   = ~csum_f2;
    hdr = {DEST_MAC, LOCAL_MAC, 16'h0800,
           8'h45, 8'h00, total_len, ident, 16'h4000, 8'h40, 8'h11, ip_csum,
           LOCAL_IP, DEST_IP,
           LOCL_PORT, DEST_PORT, udp_len, 16'h0000};
    hdr_idx  = (cnt[5:0] > 6'd41) ? 6'd0 : cnt[5:0];
    hdr_pos  = 9'd335 - {hdr_idx, 3'b000};
    hdr_byte = hdr[hdr_pos -: 8];
    crc_inv  = ~crc;
    case (cnt[1:0])
      2'd0:    fcs_byte = crc_inv[7:0];
      2'd1:    fcs_byte = crc_inv[15:8];
      2'd2:    fcs_byte = crc_inv[23:16];
      default: fcs_byte = crc_inv[31:24];
    endcase
  end

  // Next-state, counters, running CRC and the GMII/handshake outputs.
  always_comb begin
    next_state   = state;
    next_cnt     = cnt + 16'd1;
    next_len     = len;
    next_ident   = ident;
    next_crc     = crc;
    next_len_err = 1'b0;
    gmii_tx_en   = 1'b0;
    gmii_txd     = 8'h00;
    pay_rd       = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        next_cnt = 16'd0;
        if (start) begin
          if (pay_len == 16'd0) begin
            next_len_err = 1'b1;
          end else begin
            next_len   = (pay_len > MAX_LEN16) ? MAX_LEN16 : pay_len;
            next_state = PREAMBLE;
          end
        end
      end
      PREAMBLE: begin
        gmii_tx_en = 1'b1;
        gmii_txd   = (cnt == 16'd7) ? 8'hD5 : 8'h55;
        next_crc   = 32'hFFFFFFFF;
        if (cnt == 16'd7) begin
          next_state = HEADER;
          next_cnt   = 16'd0;
        end
      end
      HEADER: begin
        gmii_tx_en = 1'b1;
        gmii_txd   = hdr_byte;
        next_crc   = crc_byte(crc, hdr_byte);
        if (cnt == 16'd41) begin
          next_state = PAYLOAD;
          next_cnt   = 16'd0;
        end
      end
      PAYLOAD: begin
        gmii_tx_en = 1'b1;
        gmii_txd   = pay_data;
        pay_rd     = 1'b1;
        next_crc   = crc_byte(crc, pay_data);
        if (cnt == len - 16'd1) begin
          next_state = (len < MIN_PAY) ? PAD : FCS;
          next_cnt   = 16'd0;
        end
      end
      PAD: begin
        gmii_tx_en = 1'b1;
        next_crc   = crc_byte(crc, 8'h00);
        if (cnt == MIN_PAY - 16'd1 - len) begin
          next_state = FCS;
          next_cnt   = 16'd0;
        end
      end
      FCS: begin
        gmii_tx_en = 1'b1;
        gmii_txd   = fcs_byte;
        if (cnt == 16'd3) begin
          next_state = IFG;
          next_cnt   = 16'd0;
          next_ident = ident + 16'd1;
        end
      end
      IFG: begin
        if (cnt == IFG_LAST) begin
          done       = 1'b1;
          next_state = IDLE;
          next_cnt   = 16'd0;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 16'd0;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      len     <= 16'd0;
      ident   <= 16'd0;
      crc     <= 32'hFFFFFFFF;
      len_err <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      len     <= next_len;
      ident   <= next_ident;
      crc     <= next_crc;
      len_err <= next_len_err;
    end
  end

endmodule

// File: tb/tb_udp_frame_gen.sv
// tb_udp_frame_gen: directed scenarios with random payloads; every captured
// frame is compared byte for byte with a frame assembled in the bench from the
// protocol rules (field layout, arithmetic checksum, MSB-first CRC model).
module tb_udp_frame_gen;

  localparam logic [47:0] LOCAL_MAC = 48'ha0_b1_c2_d3_e1_e1;
  localparam logic [47:0] DEST_MAC  = 48'hff_ff_ff_ff_ff_ff;
  localparam logic [31:0] LOCAL_IP  = 32'hC0_A8_01_0B;
  localparam logic [31:0] DEST_IP   = 32'hC0_A8_01_69;
  localparam logic [15:0] LOCL_PORT = 16'h1F90;
  localparam logic [15:0] DEST_PORT = 16'h1F90;
  localparam int          MAX_LEN   = 1472;
  localparam int          IFG_CYC   = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pay_len;
  logic        pay_rd;
  logic [7:0]  pay_data;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        busy;
  logic        done;
  logic        len_err;

  logic [7:0]  pay_buf [0:2047];
  int          rd_idx;
  logic [7:0]  frame_q [$];
  logic [7:0]  exp_q [$];
  int          rd_cnt;
  int          ifg_cnt;
  bit          idle_txd_ok;
  bit          len_err_seen;
  bit          timed_out;
  logic [15:0] exp_id;
  int          n_checks = 0;
  int          n_fail = 0;

  assign pay_data = pay_buf[rd_idx[10:0]];

  always #5 clk = ~clk;

  udp_frame_gen #(
    .LOCAL_MAC(LOCAL_MAC), .DEST_MAC(DEST_MAC), .LOCAL_IP(LOCAL_IP), .DEST_IP(DEST_IP),
    .LOCL_PORT(LOCL_PORT), .DEST_PORT(DEST_PORT), .MAX_LEN(MAX_LEN), .IFG_CYC(IFG_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pay_len(pay_len), .pay_rd(pay_rd),
    .pay_data(pay_data), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
    .busy(busy), .done(done), .len_err(len_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fillRandom();
    for (int i = 0; i < 2048; i++) pay_buf[i] = 8'($urandom);
  endtask

  task automatic applyStimulus(input logic [15:0] len);
    rd_idx  = 0;
    pay_len = len;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic captureFrame(input int inject_at);
    int guard;
    bit got;
    bit rd_s;
    bit done_s;
    frame_q.delete();
    rd_cnt = 0; ifg_cnt = 0; idle_txd_ok = 1; len_err_seen = 0; timed_out = 0;
    guard = 0; got = 0; done_s = 0;
    while (guard < 4000) begin
      @(negedge clk);
      rd_s = pay_rd;
      if (len_err) len_err_seen = 1;
      if (gmii_tx_en) begin
        got = 1;
        frame_q.push_back(gmii_txd);
        if (pay_rd) rd_cnt++;
      end else begin
        if (gmii_txd !== 8'h00) idle_txd_ok = 0;
        if (got) break;
      end
      tick();
      if (rd_s) rd_idx++;
      start = (inject_at >= 0 && frame_q.size() == inject_at);
      guard++;
    end
    start = 1'b0;
    if (guard >= 4000) begin
      timed_out = 1;
    end else begin
      ifg_cnt = 1;
      done_s  = done;
      while (!done_s && ifg_cnt < 200) begin
        tick();
        @(negedge clk);
        if (gmii_tx_en || gmii_txd !== 8'h00) idle_txd_ok = 0;
        if (len_err) len_err_seen = 1;
        ifg_cnt++;
        done_s = done;
      end
      if (!done_s) timed_out = 1;
      tick();
    end
  endtask

  task automatic push16(input logic [15:0] v);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
  endtask

  task automatic push32(input logic [31:0] v);
    push16(v[31:16]);
    push16(v[15:0]);
  endtask

  task automatic push48(input logic [47:0] v);
    push16(v[47:32]);
    push32(v[31:0]);
  endtask

  // Reference CRC: non-reflected MSB-first CRC-32 on bit-reversed bytes,
  // result bit-reversed and complemented (equivalent to the 802.3 FCS).
  function automatic logic [31:0] refCrc(input int from);
    logic [31:0] c;
    logic [31:0] r;
    logic [7:0]  b;
    logic [7:0]  rb;
    c = 32'hFFFFFFFF;
    for (int k = from; k < exp_q.size(); k++) begin
      b = exp_q[k];
      for (int j = 0; j < 8; j++) rb[j] = b[7-j];
      c = c ^ {rb, 24'h000000};
      for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    for (int j = 0; j < 32; j++) r[j] = c[31-j];
    return ~r;
  endfunction

  task automatic buildExpected(input int L);
    logic [31:0] s;
    logic [31:0] fcs;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    push48(DEST_MAC);
    push48(LOCAL_MAC);
    push16(16'h0800);
    s = 32'h4500 + (L + 28) + exp_id + 32'h4000 + 32'h4011 +
        LOCAL_IP[31:16] + LOCAL_IP[15:0] + DEST_IP[31:16] + DEST_IP[15:0];
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    push16(16'h4500);
    push16(16'(L + 28));
    push16(exp_id);
    push16(16'h4000);
    push16(16'h4011);
    push16(~s[15:0]);
    push32(LOCAL_IP);
    push32(DEST_IP);
    push16(LOCL_PORT);
    push16(DEST_PORT);
    push16(16'(L + 8));
    push16(16'h0000);
    for (int i = 0; i < L; i++) exp_q.push_back(pay_buf[i]);
    for (int i = L; i < 18; i++) exp_q.push_back(8'h00);
    fcs = refCrc(8);
    push16({fcs[7:0], fcs[15:8]});
    push16({fcs[23:16], fcs[31:24]});
  endtask

  task automatic runAndCheck(input string tag, input int req_len, input int inject_at);
    int L;
    int bad;
    logic [31:0] s;
    L = (req_len > MAX_LEN) ? MAX_LEN : req_len;
    applyStimulus(16'(req_len));
    captureFrame(inject_at);
    buildExpected(L);
    checkOutput({tag, "_timeout"}, 32'(timed_out), 0);
    checkOutput({tag, "_txen_cycles"}, frame_q.size(), exp_q.size());
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= frame_q.size() || frame_q[i] !== exp_q[i]) begin
        bad = i;
        break;
      end
    end
    if (bad >= 0 && bad < frame_q.size())
      $display("[TB] %s first differing byte %0d: got 0x%02h want 0x%02h", tag, bad, frame_q[bad], exp_q[bad]);
    checkOutput({tag, "_first_bad_byte"}, bad, -1);
    checkOutput({tag, "_pay_rd_cycles"}, rd_cnt, L);
    checkOutput({tag, "_ifg_cycles"}, ifg_cnt, IFG_CYC);
    checkOutput({tag, "_idle_txd_zero"}, 32'(idle_txd_ok), 1);
    checkOutput({tag, "_no_len_err"}, 32'(len_err_seen), 0);
    if (frame_q.size() >= 42) begin
      s = 0;
      for (int i = 0; i < 10; i++) s = s + {frame_q[22+2*i], frame_q[23+2*i]};
      s = (s & 32'hFFFF) + (s >> 16);
      s = (s & 32'hFFFF) + (s >> 16);
      checkOutput({tag, "_ip_csum_sum"}, s, 32'hFFFF);
    end
    exp_id++;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_id = 16'h0000;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rd_seen;
    int guard;
    int high_cnt;
    rst = 1'b1; start = 1'b0; pay_len = 16'd0; rd_idx = 0; exp_id = 16'h0000;
    fillRandom();

    $display("[TB] reset state");
    doReset();
    @(negedge clk);
    checkOutput("rst_tx_en", 32'(gmii_tx_en), 0);
    checkOutput("rst_txd", 32'(gmii_txd), 0);
    checkOutput("rst_pay_rd", 32'(pay_rd), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_len_err", 32'(len_err), 0);
    tick();

    $display("[TB] L=4 fixed payload");
    fillRandom();
    for (int i = 0; i < 4; i++) pay_buf[i] = 8'(i + 1);
    runAndCheck("l4", 4, -1);
    checkOutput("l4_total_len", {frame_q[24], frame_q[25]}, 32'h0020);
    checkOutput("l4_udp_len", {frame_q[46], frame_q[47]}, 32'h000C);
    @(negedge clk);
    checkOutput("l4_busy_after_done", 32'(busy), 0);
    tick();

    $display("[TB] zero length rejected");
    pay_len = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    checkOutput("zero_len_err", 32'(len_err), 1);
    checkOutput("zero_busy", 32'(busy), 0);
    tick();
    @(negedge clk);
    checkOutput("zero_len_err_pulse", 32'(len_err), 0);
    checkOutput("zero_busy_later", 32'(busy), 0);
    checkOutput("zero_tx_en", 32'(gmii_tx_en), 0);
    tick();

    $display("[TB] maximum length");
    fillRandom();
    runAndCheck("lmax", MAX_LEN, -1);
    checkOutput("lmax_total_len", {frame_q[24], frame_q[25]}, 32'h05DC);

    $display("[TB] oversize length clamped");
    fillRandom();
    runAndCheck("l2000", 2000, -1);

    $display("[TB] reset has priority over start");
    rst = 1'b1; start = 1'b1; pay_len = 16'd4;
    tick();
    tick();
    rst = 1'b0; start = 1'b0;
    exp_id = 16'h0000;
    @(negedge clk);
    checkOutput("rst_prio_busy", 32'(busy), 0);
    checkOutput("rst_prio_tx_en", 32'(gmii_tx_en), 0);
    tick();

    $display("[TB] back-to-back frames");
    fillRandom();
    runAndCheck("b2b_first", int'($urandom_range(1, 40)), -1);
    checkOutput("b2b_id0", {frame_q[26], frame_q[27]}, 32'h0000);
    fillRandom();
    runAndCheck("b2b_second", int'($urandom_range(1, 40)), -1);
    checkOutput("b2b_id1", {frame_q[26], frame_q[27]}, 32'h0001);

    $display("[TB] reset during payload");
    fillRandom();
    applyStimulus(16'd30);
    rd_seen = 0;
    guard = 0;
    while (rd_seen < 3 && guard < 200) begin
      @(negedge clk);
      if (pay_rd) rd_seen++;
      tick();
      guard++;
    end
    checkOutput("mid_rst_reached_payload", 32'(rd_seen), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_id = 16'h0000;
    @(negedge clk);
    checkOutput("mid_rst_tx_en", 32'(gmii_tx_en), 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_pay_rd", 32'(pay_rd), 0);
    tick();
    fillRandom();
    runAndCheck("after_rst", 4, -1);
    checkOutput("after_rst_id", {frame_q[26], frame_q[27]}, 32'h0000);

    $display("[TB] start during header");
    fillRandom();
    runAndCheck("hdr_start", 10, 28);
    high_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gmii_tx_en || busy) high_cnt++;
      tick();
    end
    checkOutput("hdr_start_single_frame", high_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
